video_stream_timing_gen: RTL and testbench

- Synthesizable raster timing generator that feeds the 24bpp video sink and PPM frame writer model.
- Produces active-high vsync/hsync pulses, a de qualifier and 24-bit RGB pixel data per frame.
- Pulls pixels from the frame-memory read path through a valid/ready handshake.
- Supports start/stop at frame boundaries, a frame counter and sticky underflow detection.

---
 rtl/video_stream_timing_gen.sv | 136 +++++++++++++
 tb/tb_video_stream_timing_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_timing_gen.sv
// Raster timing generator: sync/de pulses and pixel pull from frame memory.
// Starts and stops on frame boundaries; counts frames and flags underflow.
module video_stream_timing_gen #(
  parameter int DATA_WIDTH = 24,
  parameter int HRES       = 320,
  parameter int VRES       = 240,
  parameter int HSYNC      = 4,
  parameter int HBP        = 8,
  parameter int HFP        = 8,
  parameter int VSYNC      = 2,
  parameter int VBP        = 4,
  parameter int VFP        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_pix_valid,
  input  logic [DATA_WIDTH-1:0] i_pix_data,
  output logic                  o_pix_ready,
  output logic                  o_vsync,
  output logic                  o_hsync,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [15:0]           o_frame_cnt,
  output logic                  o_underflow,
  output logic                  o_busy
);

  localparam int HTOT = HSYNC + HBP + HRES + HFP;
  localparam int VTOT = VSYNC + VBP + VRES + VFP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);
  localparam int HA0  = HSYNC + HBP;
  localparam int HA1  = HA0 + HRES;
  localparam int VA0  = VSYNC + VBP;
  localparam int VA1  = VA0 + VRES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t                r_state;
  logic [HW-1:0]         r_h;
  logic [VW-1:0]         r_v;
  logic [15:0]           r_frame_cnt;
  logic                  r_vsync;
  logic                  r_hsync;
  logic                  r_de;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_underflow;

  logic w_on;
  logic w_h_last;
  logic w_v_last;
  logic w_frame_last;
  logic w_hsync;
  logic w_vsync;
  logic w_active;
  logic w_frame_start;

  assign w_on          = (r_state != S_IDLE);
  assign w_h_last      = (r_h == HW'(HTOT - 1));
  assign w_v_last      = (r_v == VW'(VTOT - 1));
  assign w_frame_last  = w_h_last && w_v_last;
  assign w_hsync       = (int'(r_h) < HSYNC);
  assign w_vsync       = (int'(r_v) < VSYNC);
  assign w_active      = (int'(r_h) >= HA0) && (int'(r_h) < HA1) &&
                         (int'(r_v) >= VA0) && (int'(r_v) < VA1);
  assign w_frame_start = (r_state == S_RUN) && (r_h == '0) && (r_v == '0);

  assign o_pix_ready = w_on && w_active;
  assign o_vsync     = r_vsync;
  assign o_hsync     = r_hsync;
  assign o_de        = r_de;
  assign o_data      = r_data;
  assign o_frame_cnt = r_frame_cnt;
  assign o_underflow = r_underflow;
  assign o_busy      = w_on;

  // Raster position: held at origin while idle, free-running otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!w_on) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  // Run/stop control on frame boundaries plus frame-start counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_frame_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (i_en) r_state <= S_RUN;
        S_RUN: begin
          if (!i_en) r_state <= w_frame_last ? S_IDLE : S_STOP;
        end
        S_STOP: begin
          if (i_en) r_state <= S_RUN;
          else if (w_frame_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_frame_start) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Sync/de/data pipeline register and sticky underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync     <= 1'b0;
      r_hsync     <= 1'b0;
      r_de        <= 1'b0;
      r_data      <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_vsync <= w_on && w_vsync;
      r_hsync <= w_on && w_hsync;
      r_de    <= o_pix_ready;
      r_data  <= (o_pix_ready && i_pix_valid) ? i_pix_data : '0;
      if (o_pix_ready && !i_pix_valid) r_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_video_stream_timing_gen.sv
// Self-checking bench for video_stream_timing_gen on a shrunken raster.
// Frame-level reference model plus directed segment table and corner cases.
module tb_video_stream_timing_gen;

  localparam int DW    = 24;
  localparam int HRES  = 6;
  localparam int VRES  = 4;
  localparam int HSYNC = 2;
  localparam int HBP   = 3;
  localparam int HFP   = 2;
  localparam int VSYNC = 2;
  localparam int VBP   = 1;
  localparam int VFP   = 2;
  localparam int HTOT  = 13;
  localparam int VTOT  = 9;
  localparam int FRAME = 117;
  localparam int PIX   = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_en = 1'b0;
  logic          i_pix_valid = 1'b0;
  logic [DW-1:0] i_pix_data = '0;
  logic          o_pix_ready;
  logic          o_vsync;
  logic          o_hsync;
  logic          o_de;
  logic [DW-1:0] o_data;
  logic [15:0]   o_frame_cnt;
  logic          o_underflow;
  logic          o_busy;

  video_stream_timing_gen #(
    .DATA_WIDTH(DW), .HRES(HRES), .VRES(VRES),
    .HSYNC(HSYNC), .HBP(HBP), .HFP(HFP),
    .VSYNC(VSYNC), .VBP(VBP), .VFP(VFP)
  ) dut (
    .clk(clk), .rst(rst), .i_en(i_en),
    .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data),
    .o_pix_ready(o_pix_ready), .o_vsync(o_vsync),
    .o_hsync(o_hsync), .o_de(o_de), .o_data(o_data),
    .o_frame_cnt(o_frame_cnt), .o_underflow(o_underflow),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int de_cnt = 0;
  int last_rise = -1;
  bit chk_period = 0;
  logic prev_vs = 1'b0;
  logic [DW-1:0] dcnt = '0;

  // reference model: frame position and expected registered outputs
  bit          m_busy;
  int          m_pos;
  logic        m_vs, m_hs, m_de, m_uf;
  logic [DW-1:0] m_data;
  logic [15:0] m_fc;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs();
    return {19'd0, o_vsync, o_hsync, o_de, o_busy, o_underflow,
            o_frame_cnt, o_data};
  endfunction

  function automatic logic [63:0] model_outs();
    return {19'd0, m_vs, m_hs, m_de, m_busy, m_uf, m_fc, m_data};
  endfunction

  task automatic model_clear();
    m_busy = 0; m_pos = 0; m_vs = 0; m_hs = 0; m_de = 0;
    m_uf = 0; m_data = '0; m_fc = '0;
  endtask

  // one clock: check ready, advance model, check registered outputs
  task automatic step(input logic en, input logic v, input logic [DW-1:0] d);
    int h, ln;
    bit act;
    i_en = en; i_pix_valid = v; i_pix_data = d;
    #1;
    h  = m_pos % HTOT;
    ln = m_pos / HTOT;
    act = m_busy && h >= HSYNC + HBP && h < HSYNC + HBP + HRES &&
          ln >= VSYNC + VBP && ln < VSYNC + VBP + VRES;
    chk("ready", {63'd0, o_pix_ready}, {63'd0, act});
    m_vs   = m_busy && ln < VSYNC;
    m_hs   = m_busy && h < HSYNC;
    m_de   = act;
    m_data = (act && v) ? d : '0;
    if (act && !v) m_uf = 1'b1;
    if (m_busy && m_pos == 0) m_fc = m_fc + 16'd1;
    if (!m_busy || m_pos == FRAME - 1) begin
      m_busy = en;
      m_pos  = 0;
    end else begin
      m_pos++;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("outs", outs(), model_outs());
    if (o_de) de_cnt++;
    if (o_vsync && !prev_vs && chk_period) begin
      if (last_rise >= 0) chk("vs_period", 64'(cyc - last_rise), 64'(FRAME));
      last_rise = cyc;
    end
    prev_vs = o_vsync;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_en = 0; i_pix_valid = 0; i_pix_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_outs", outs(), 64'd0);
    chk("reset_ready", {63'd0, o_pix_ready}, 64'd0);
    rst = 1'b0;
    model_clear();
    prev_vs = 1'b0;
  endtask

  typedef struct {
    logic        en;
    int          cycles;
    int          exp_de;
    logic [15:0] exp_fc;
    logic        exp_busy;
  } seg_t;

  seg_t tbl[6];

  initial begin
    int drop;
    model_clear();
    tbl[0] = '{1'b0, 5,     0,   16'd0, 1'b0};
    tbl[1] = '{1'b1, 1,     0,   16'd0, 1'b1};
    tbl[2] = '{1'b1, FRAME, PIX, 16'd1, 1'b1};
    tbl[3] = '{1'b1, FRAME, PIX, 16'd2, 1'b1};
    tbl[4] = '{1'b0, FRAME, PIX, 16'd3, 1'b0};
    tbl[5] = '{1'b0, 10,    0,   16'd3, 1'b0};

    #1;
    do_reset();

    // directed segments: idle, start, two back-to-back frames, stop
    for (int i = 0; i < 6; i++) begin
      de_cnt = 0;
      chk_period = (i >= 2 && i <= 4);
      for (int c = 0; c < tbl[i].cycles; c++) begin
        step(tbl[i].en, 1'b1, dcnt);
        dcnt++;
      end
      chk($sformatf("seg%0d_de", i), 64'(de_cnt), 64'(tbl[i].exp_de));
      chk($sformatf("seg%0d_fc", i), {48'd0, o_frame_cnt},
          {48'd0, tbl[i].exp_fc});
      chk($sformatf("seg%0d_busy", i), {63'd0, o_busy},
          {63'd0, tbl[i].exp_busy});
      chk($sformatf("seg%0d_uf", i), {63'd0, o_underflow}, 64'd0);
    end
    chk_period = 0;
    chk("vs_rises_seen", {63'd0, last_rise >= 0}, 64'd1);

    // three-pixel dropout, i_en released mid-active region
    de_cnt = 0;
    drop = 0;
    step(1'b1, 1'b1, dcnt++);
    chk("uf_pre", {63'd0, o_underflow}, 64'd0);
    for (int p = 0; p < FRAME; p++) begin
      if (o_pix_ready && drop < 3) begin
        drop++;
        step(p < 60, 1'b0, dcnt++);
      end else begin
        step(p < 60, 1'b1, dcnt++);
      end
    end
    chk("uf_drops", 64'(drop), 64'd3);
    chk("uf_set", {63'd0, o_underflow}, 64'd1);
    chk("uf_de_cnt", 64'(de_cnt), 64'(PIX));
    chk("stop_busy", {63'd0, o_busy}, 64'd0);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1, dcnt++);
    chk("stop_syncs", {62'd0, o_vsync, o_hsync}, 64'd0);
    step(1'b1, 1'b1, dcnt++);
    for (int p = 0; p < FRAME; p++) step(1'b0, 1'b1, dcnt++);
    chk("uf_sticky", {63'd0, o_underflow}, 64'd1);

    // asynchronous reset inside an active line
    step(1'b1, 1'b1, dcnt++);
    for (int p = 0; p < 4 * HTOT + 8; p++) step(1'b1, 1'b1, dcnt++);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outs", outs(), 64'd0);
    chk("async_rst_ready", {63'd0, o_pix_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    prev_vs = 1'b0;
    de_cnt = 0;
    step(1'b1, 1'b1, dcnt++);
    step(1'b1, 1'b1, dcnt++);
    chk("rst_fc_restart", {48'd0, o_frame_cnt}, 64'd1);
    for (int p = 1; p < FRAME; p++) step(1'b0, 1'b1, dcnt++);
    chk("rst_frame_de", 64'(de_cnt), 64'(PIX));

    // frame counter wrap from 0xFFFF
    force dut.r_frame_cnt = 16'hFFFF;
    m_fc = 16'hFFFF;
    step(1'b0, 1'b1, dcnt++);
    release dut.r_frame_cnt;
    step(1'b0, 1'b1, dcnt++);
    chk("fc_preload", {48'd0, o_frame_cnt}, 64'h0000FFFF);
    step(1'b1, 1'b1, dcnt++);
    step(1'b1, 1'b1, dcnt++);
    chk("fc_wrap", {48'd0, o_frame_cnt}, 64'd0);
    for (int p = 1; p < FRAME; p++) step(1'b0, 1'b1, dcnt++);

    // randomized run/stop and valid patterns against the model
    do_reset();
    begin
      logic en_r;
      en_r = 1'b1;
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 49) == 0) en_r = ~en_r;
        step(en_r, $urandom_range(0, 3) != 0, DW'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
